ss_rd_chan: RTL and testbench

Per-channel source engine on the channel side of the DMA controller's ss_*/c_done interface. It captures the 4-word descriptor image the controller writes over ss_we/ss_adr/ss_dat, then bursts the source buffer from memory as a 64-bit Wishbone master. Read data is buffered in an internal FIFO and presented as a 64-bit valid/ready stream to the downstream engine. It raises c_done once every beat has been delivered, and returns to idle on the controller's ss_done pulse.

---
 rtl/ss_defs_pkg.sv | 29 ++
 rtl/ss_sync_fifo.sv | 70 +++++++
 rtl/ss_rd_chan.sv | 258 +++++++++++++++++++++++++
 tb/tb_ss_rd_chan.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_defs_pkg.sv
// Shared definitions for the DMA channel source engine: descriptor layout,
// channel state encodings and the buffered read-beat payload.
package ss_defs;

   localparam logic [1:0] W_NEXT = 2'd0;
   localparam logic [1:0] W_DC   = 2'd1;
   localparam logic [1:0] W_SRC  = 2'd2;
   localparam logic [1:0] W_CNT  = 2'd3;

   localparam int unsigned DC_CTL   = 7;
   localparam int unsigned DC_CHAIN = 14;
   localparam int unsigned DC_INT   = 15;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_REQ   = 4'd1,
      ST_BUS   = 4'd2,
      ST_DRAIN = 4'd3,
      ST_DONE  = 4'd4
   } chan_state_t;

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } beat_t;

   localparam int unsigned BEAT_W = $bits(beat_t);

endpackage

// File: rtl/ss_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/free flags.
module ss_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_n;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      count_n = count;
      if (clr)
         count_n = '0;
      else
         count_n = count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         free   <= CW'(DEPTH);
      end else begin
         count <= count_n;
         empty <= (count_n == '0);
         full  <= (count_n == CW'(DEPTH));
         free  <= CW'(DEPTH) - count_n;
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ss_rd_chan.sv
// DMA channel source engine: captures a descriptor, bursts the source buffer
// over a 64-bit Wishbone master and streams the beats out through a FIFO.
module ss_rd_chan
   import ss_defs::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned BURST_MAX  = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        ss_we,
   input  logic [1:0]  ss_adr,
   input  logic [31:0] ss_dat,
   input  logic [23:0] ss_dc,
   input  logic        ss_done,
   input  logic        m_reset,
   output logic        c_done,
   output logic        err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_cab_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   input  logic [31:0] wbm_dat_i,
   input  logic [31:0] wbm_dat64_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   output logic        st_valid,
   output logic [63:0] st_data,
   output logic        st_last,
   input  logic        st_ready,
   output logic [3:0]  chan_state
);

   localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned RW = CNT_W - 3;
   localparam int unsigned BW = $clog2(BURST_MAX + 1);

   chan_state_t   state_q, state_n;
   logic [31:0]   word_q [4];
   logic          arm_q;
   logic          cyc_q, cyc_n;
   logic          stb_q, stb_n;
   logic          cab_q, cab_n;
   logic [3:0]    sel_q;
   logic [31:0]   adr_q, adr_n;
   logic [RW-1:0] rem_q, rem_n;
   logic [BW-1:0] burst_q, burst_n;
   logic          c_done_q, c_done_n;
   logic          err_q, err_n;

   logic          desc_we;
   logic [RW-1:0] beats;
   logic [31:0]   src;
   logic [BW-1:0] burst_load;
   logic          bus_live;
   logic          rsp_ack, rsp_err, rsp_rty;
   logic          push, flush, pop;
   beat_t         push_beat, pop_beat;
   logic          fifo_full, fifo_empty;
   logic [FW-1:0] fifo_free;
   logic [FW-1:0] free_after_push;
   logic          unused_bits;

   assign desc_we = ss_we & (state_q == ST_IDLE);
   assign beats   = word_q[W_CNT][CNT_W-1:3];
   assign src     = {word_q[W_SRC][31:3], 3'b000};

   assign burst_load = (rem_q > RW'(BURST_MAX)) ? BW'(BURST_MAX) : BW'(rem_q);

   // Responses only count while a strobe is out and exactly one is asserted.
   assign bus_live = cyc_q & stb_q;
   assign rsp_ack  = bus_live &  wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
   assign rsp_err  = bus_live & ~wbm_ack_i &  wbm_err_i & ~wbm_rty_i;
   assign rsp_rty  = bus_live & ~wbm_ack_i & ~wbm_err_i &  wbm_rty_i;

   assign pop             = ~fifo_empty & st_ready;
   assign free_after_push = fifo_free - FW'(1) + FW'(pop);

   assign push_beat.last = (rem_q == RW'(1));
   assign push_beat.data = {wbm_dat64_i, wbm_dat_i};

   always_comb begin
      state_n  = state_q;
      cyc_n    = cyc_q;
      stb_n    = stb_q;
      cab_n    = cab_q;
      adr_n    = adr_q;
      rem_n    = rem_q;
      burst_n  = burst_q;
      c_done_n = c_done_q;
      err_n    = err_q;
      push     = 1'b0;
      flush    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arm_q) begin
               adr_n = src;
               rem_n = beats;
               if (beats == '0 || ss_dc == 24'd0) begin
                  state_n  = ST_DONE;
                  c_done_n = 1'b1;
               end else begin
                  state_n = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (fifo_free >= FW'(2)) begin
               cyc_n   = 1'b1;
               stb_n   = 1'b1;
               cab_n   = 1'b1;
               burst_n = burst_load;
               state_n = ST_BUS;
            end
         end
         ST_BUS: begin
            if (stb_q) begin
               if (rsp_ack) begin
                  push    = 1'b1;
                  adr_n   = adr_q + 32'd8;
                  rem_n   = rem_q - RW'(1);
                  burst_n = burst_q - BW'(1);
                  if (rem_n == '0 || burst_n == '0) begin
                     cyc_n   = 1'b0;
                     stb_n   = 1'b0;
                     cab_n   = 1'b0;
                     state_n = (rem_n == '0) ? ST_DRAIN : ST_REQ;
                  end else if (free_after_push <= FW'(1)) begin
                     stb_n = 1'b0;
                  end
               end else if (rsp_rty) begin
                  cyc_n   = 1'b0;
                  stb_n   = 1'b0;
                  cab_n   = 1'b0;
                  state_n = ST_REQ;
               end else if (rsp_err) begin
                  cyc_n    = 1'b0;
                  stb_n    = 1'b0;
                  cab_n    = 1'b0;
                  err_n    = 1'b1;
                  c_done_n = 1'b1;
                  flush    = 1'b1;
                  state_n  = ST_DONE;
               end
            end else if (fifo_free >= FW'(2)) begin
               // Bus held while the FIFO drains; resume the strobe.
               stb_n = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               c_done_n = 1'b1;
               state_n  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ss_done) begin
               c_done_n = 1'b0;
               err_n    = 1'b0;
               state_n  = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (m_reset) begin
         state_n  = ST_IDLE;
         cyc_n    = 1'b0;
         stb_n    = 1'b0;
         cab_n    = 1'b0;
         adr_n    = '0;
         rem_n    = '0;
         burst_n  = '0;
         c_done_n = 1'b0;
         err_n    = 1'b0;
         push     = 1'b0;
         flush    = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         cab_q    <= 1'b0;
         sel_q    <= 4'b0000;
         adr_q    <= '0;
         rem_q    <= '0;
         burst_q  <= '0;
         c_done_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         cyc_q    <= cyc_n;
         stb_q    <= stb_n;
         cab_q    <= cab_n;
         sel_q    <= {4{cyc_n}};
         adr_q    <= adr_n;
         rem_q    <= rem_n;
         burst_q  <= burst_n;
         c_done_q <= c_done_n;
         err_q    <= err_n;
      end
   end

   // Descriptor image; writing the count word arms the start.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < 4; i++) word_q[i] <= '0;
         arm_q <= 1'b0;
      end else if (m_reset) begin
         for (int i = 0; i < 4; i++) word_q[i] <= '0;
         arm_q <= 1'b0;
      end else begin
         arm_q <= desc_we & (ss_adr == W_CNT);
         if (desc_we) word_q[ss_adr] <= ss_dat;
      end
   end

   ss_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .clr       (flush),
      .push      (push),
      .push_data (push_beat),
      .pop       (pop),
      .pop_data  (pop_beat),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .free      (fifo_free)
   );

   assign unused_bits = ^{word_q[W_NEXT], word_q[W_DC], word_q[W_SRC][2:0],
                          word_q[W_CNT][31:CNT_W], word_q[W_CNT][2:0], fifo_full};

   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = stb_q;
   assign wbm_cab_o  = cab_q;
   assign wbm_we_o   = 1'b0;
   assign wbm_sel_o  = sel_q;
   assign wbm_adr_o  = adr_q;
   assign c_done     = c_done_q;
   assign err_o      = err_q;
   assign st_valid   = ~fifo_empty;
   assign st_data    = pop_beat.data;
   assign st_last    = pop_beat.last;
   assign chan_state = state_q;

endmodule

// File: tb/tb_ss_rd_chan.sv
// Scenario bench for ss_rd_chan: a Wishbone slave model with a scoreboard of
// expected bus addresses and stream beats.
`timescale 1ns/1ps
module tb_ss_rd_chan;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned BURST_MAX  = 4;
   localparam int unsigned CNT_W      = 16;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        ss_we = 1'b0;
   logic [1:0]  ss_adr = '0;
   logic [31:0] ss_dat = '0;
   logic [23:0] ss_dc = 24'h000080;
   logic        ss_done = 1'b0;
   logic        m_reset = 1'b1;
   logic        c_done, err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_i = '0;
   logic [31:0] wbm_dat64_i = '0;
   logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
   logic        st_valid, st_last;
   logic [63:0] st_data;
   logic        st_ready = 1'b1;
   logic [3:0]  chan_state;

   ss_rd_chan #(.FIFO_DEPTH(FIFO_DEPTH), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .ss_we(ss_we), .ss_adr(ss_adr),
      .ss_dat(ss_dat), .ss_dc(ss_dc), .ss_done(ss_done), .m_reset(m_reset),
      .c_done(c_done), .err_o(err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_cab_o(wbm_cab_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_dat64_i(wbm_dat64_i),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
      .st_valid(st_valid), .st_data(st_data), .st_last(st_last),
      .st_ready(st_ready), .chan_state(chan_state)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] adr_exp[$];
   int          burst_len[$];

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int acks, pops, beat_idx, rty_beat = -1, err_beat = -1, run, cyc_seen;
   int last_pop_cyc, rty_cyc, err_cyc;
   logic [31:0] rty_adr;
   bit rty_gap_pending;

   function automatic logic [31:0] lo_of(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] hi_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   always @(posedge wb_clk_i) cyc_cnt++;

   // Slave model and stream monitor, evaluated mid-low-phase.
   always @(negedge wb_clk_i) begin
      exp_t        e;
      logic [31:0] ea;
      #2;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      if (!wb_rst_i) begin
         if (wbm_cyc_o) cyc_seen++;
         if (wbm_cyc_o && wbm_stb_o) begin
            checks++;
            if (acks - pops > int'(FIFO_DEPTH) - 2) begin
               errors++;
               $display("FAIL fifo_headroom: occupancy %0d with stb high, limit %0d", acks - pops, FIFO_DEPTH - 2);
            end
            if (rty_gap_pending) begin
               checks++;
               if (cyc_cnt - rty_cyc != 2 || wbm_adr_o !== rty_adr) begin
                  errors++;
                  $display("FAIL rty_reissue: gap %0d adr %h, expected gap 2 adr %h", cyc_cnt - rty_cyc, wbm_adr_o, rty_adr);
               end
               rty_gap_pending = 1'b0;
            end
            if (beat_idx == err_beat) begin
               wbm_err_i = 1'b1;
               err_cyc   = cyc_cnt;
               err_beat  = -1;
            end else if (beat_idx == rty_beat) begin
               wbm_rty_i       = 1'b1;
               rty_cyc         = cyc_cnt;
               rty_adr         = wbm_adr_o;
               rty_beat        = -1;
               rty_gap_pending = 1'b1;
            end else begin
               wbm_ack_i   = 1'b1;
               wbm_dat_i   = lo_of(wbm_adr_o);
               wbm_dat64_i = hi_of(wbm_adr_o);
               checks++;
               if (adr_exp.size() == 0) begin
                  errors++;
                  $display("FAIL bus_extra: read at %h with no read expected", wbm_adr_o);
               end else begin
                  ea = adr_exp.pop_front();
                  if (wbm_adr_o !== ea || wbm_sel_o !== 4'hF || wbm_we_o !== 1'b0) begin
                     errors++;
                     $display("FAIL bus_read: adr %h sel %h we %b, expected adr %h sel f we 0", wbm_adr_o, wbm_sel_o, wbm_we_o, ea);
                  end
               end
               acks++;
               beat_idx++;
               run++;
            end
         end else if (!wbm_cyc_o && run > 0) begin
            burst_len.push_back(run);
            run = 0;
         end
         if (st_valid && st_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra: beat %h last %b with none expected", st_data, st_last);
            end else begin
               e = exp_q.pop_front();
               if (st_data !== e.data || st_last !== e.last) begin
                  errors++;
                  $display("FAIL stream_beat: got %h last %b, expected %h last %b", st_data, st_last, e.data, e.last);
               end
            end
            if (st_last) last_pop_cyc = cyc_cnt;
         end
      end
   end

   task automatic start_desc(input logic [31:0] src, input logic [31:0] cnt,
                             input int rty_b, input int err_b);
      logic [31:0] words [4];
      logic [31:0] a;
      exp_t        e;
      int          n;
      exp_q.delete();
      adr_exp.delete();
      burst_len.delete();
      acks = 0; pops = 0; beat_idx = 0; run = 0; cyc_seen = 0;
      rty_beat = rty_b;
      err_beat = err_b;
      rty_gap_pending = 1'b0;
      n = int'(cnt[CNT_W-1:3]);
      for (int i = 0; i < n; i++) begin
         a = {src[31:3], 3'b000} + 32'(i * 8);
         adr_exp.push_back(a);
         e.data = {hi_of(a), lo_of(a)};
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
      words = '{32'h0, 32'h4000, src, cnt};
      for (int w = 0; w < 4; w++) begin
         @(negedge wb_clk_i);
         ss_we  = 1'b1;
         ss_adr = 2'(w);
         ss_dat = words[w];
      end
      @(negedge wb_clk_i);
      ss_we = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge wb_clk_i);
         n++;
      end while (!c_done && n < budget);
      checks++;
      if (!c_done) begin
         errors++;
         $display("FAIL %s_timeout: c_done still %b after %0d cycles, expected 1", tag, c_done, n);
      end
   endtask

   task automatic pulse_ss_done(input string tag);
      @(negedge wb_clk_i);
      ss_done = 1'b1;
      @(negedge wb_clk_i);
      ss_done = 1'b0;
      checks++;
      if (c_done !== 1'b0 || err_o !== 1'b0 || chan_state !== 4'd0) begin
         errors++;
         $display("FAIL %s_release: c_done %b err %b state %0d, expected 0 0 0", tag, c_done, err_o, chan_state);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      m_reset = 1'b0;
      @(negedge wb_clk_i);
      checks++;
      if ({c_done, err_o, wbm_cyc_o, wbm_stb_o, wbm_cab_o, st_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: done/err/cyc/stb/cab/valid %b, expected 000000",
                  {c_done, err_o, wbm_cyc_o, wbm_stb_o, wbm_cab_o, st_valid});
      end
      checks++;
      if (chan_state !== 4'd0 || wbm_adr_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: state %0d adr %h, expected 0 00000000", chan_state, wbm_adr_o);
      end
   endtask

   task automatic test_single_burst();
      st_ready = 1'b1;
      start_desc(32'h1000, 32'h20, -1, -1);
      wait_done(200, "single");
      checks++;
      if (cyc_cnt - last_pop_cyc != 2) begin
         errors++;
         $display("FAIL single_done_lat: c_done %0d cycles after last pop, expected 1", cyc_cnt - last_pop_cyc - 1);
      end
      checks++;
      if (burst_len.size() != 1 || burst_len[0] != 4 || pops != 4) begin
         errors++;
         $display("FAIL single_burst: %0d bursts first %0d, %0d beats, expected 1 burst of 4, 4 beats",
                  burst_len.size(), (burst_len.size() > 0) ? burst_len[0] : 0, pops);
      end
      pulse_ss_done("single");
   endtask

   task automatic test_multi_burst();
      int exp_b [3] = '{4, 4, 2};
      start_desc(32'h2000, 32'h50, -1, -1);
      wait_done(300, "multi");
      checks++;
      if (burst_len.size() != 3 || pops != 10 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL multi_count: %0d bursts %0d beats %0d pending, expected 3 10 0", burst_len.size(), pops, exp_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (burst_len[i] != exp_b[i]) begin
               errors++;
               $display("FAIL multi_burst%0d: length %0d, expected %0d", i, burst_len[i], exp_b[i]);
            end
         end
      end
      pulse_ss_done("multi");
   endtask

   task automatic test_backpressure();
      st_ready = 1'b0;
      start_desc(32'h3000, 32'h80, -1, -1);
      repeat (30) @(negedge wb_clk_i);
      checks++;
      if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b0 || acks != 7) begin
         errors++;
         $display("FAIL bp_stall: cyc %b stb %b acks %0d, expected 1 0 7", wbm_cyc_o, wbm_stb_o, acks);
      end
      st_ready = 1'b1;
      wait_done(400, "bp");
      checks++;
      if (pops != 16 || exp_q.size() != 0 || adr_exp.size() != 0) begin
         errors++;
         $display("FAIL bp_delivered: %0d beats, %0d beats / %0d reads pending, expected 16 0 0", pops, exp_q.size(), adr_exp.size());
      end
      pulse_ss_done("bp");
   endtask

   task automatic test_retry();
      start_desc(32'h4008, 32'h40, 2, -1);
      wait_done(300, "rty");
      checks++;
      if (rty_beat != -1 || pops != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rty_stream: retry armed %0d, %0d beats, %0d pending, expected -1 8 0", rty_beat, pops, exp_q.size());
      end
      pulse_ss_done("rty");
   endtask

   task automatic test_error();
      st_ready = 1'b0;
      start_desc(32'h5000, 32'h20, -1, 1);
      wait_done(100, "err");
      checks++;
      if (cyc_cnt != err_cyc + 1 || wbm_cyc_o !== 1'b0 || err_o !== 1'b1 || st_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_end: done after %0d cycles cyc %b err %b valid %b, expected 1 0 1 0",
                  cyc_cnt - err_cyc, wbm_cyc_o, err_o, st_valid);
      end
      exp_q.delete();
      adr_exp.delete();
      pulse_ss_done("err");
      st_ready = 1'b1;
   endtask

   task automatic test_reset_mid_and_zero();
      int n = 0;
      start_desc(32'h6000, 32'h80, -1, -1);
      while (!(wbm_cyc_o && wbm_stb_o) && n < 50) begin
         @(negedge wb_clk_i);
         n++;
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      #1;
      checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || c_done !== 1'b0 || st_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: cyc %b stb %b done %b valid %b, expected 0 0 0 0", wbm_cyc_o, wbm_stb_o, c_done, st_valid);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      exp_q.delete();
      adr_exp.delete();
      start_desc(32'h7000, 32'h0, -1, -1);
      wait_done(20, "zero");
      checks++;
      if (cyc_seen != 0) begin
         errors++;
         $display("FAIL zero_nobus: cyc seen %0d cycles, expected 0", cyc_seen);
      end
      pulse_ss_done("zero");
      ss_dc = 24'd0;
      start_desc(32'h7100, 32'h20, -1, -1);
      wait_done(20, "nulldc");
      checks++;
      if (cyc_seen != 0 || pops != 0) begin
         errors++;
         $display("FAIL nulldc_nobus: cyc seen %0d beats %0d, expected 0 0", cyc_seen, pops);
      end
      exp_q.delete();
      adr_exp.delete();
      pulse_ss_done("nulldc");
      ss_dc = 24'h000080;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_multi_burst();
      test_backpressure();
      test_retry();
      test_error();
      test_reset_mid_and_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
